// File: rtl/endec_stream_host.sv
// endec_stream_host: streams config and payload to an encode/decode engine and collects its response.
// Define ENDEC_HOST_TIMEOUT_EN to enable the TIMEOUT_CYCLES watchdog; o_timeout is otherwise tied low.
module endec_stream_host #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic         sys_clk,
  input  logic         rst_n,
  input  logic         i_start,
  input  logic         i_mode,
  input  logic         i_code_rate,
  input  logic         i_constr_len,
  input  logic [26:0]  i_gen_poly,
  input  logic [383:0] i_tx_frame,
  output logic         o_busy,
  output logic         o_done,
  output logic [383:0] o_rx_frame,
  output logic         o_len_err,
  output logic         o_timeout,
  output logic [31:0]  m_axis_tdata,
  output logic         m_axis_tvalid,
  output logic         m_axis_tlast,
  input  logic         m_axis_tready,
  input  logic [31:0]  s_axis_tdata,
  input  logic         s_axis_tvalid,
  input  logic         s_axis_tlast,
  output logic         s_axis_tready
);
  typedef enum logic [2:0] {IDLE, CONF, DATA, RECV, DONE} state_t;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d, widx;
  logic mode_q, mode_d, rate_q, rate_d, constr_q, constr_d, len_err_q, len_err_d;
  logic [26:0] poly_q, poly_d;
  logic [383:0] tx_q, tx_d, rx_q, rx_d;
  logic m_hs, s_hs, s_end, act, expire;
  assign act = state_q == CONF || state_q == DATA || state_q == RECV;
  assign m_hs = m_axis_tvalid && m_axis_tready;
  assign s_hs = s_axis_tvalid && s_axis_tready;
  assign s_end = cnt_q == (mode_q ? 4'd3 : 4'd11);
  assign widx = mode_q ? 4'd3 - cnt_q : 4'd11 - cnt_q;
  assign o_busy = state_q != IDLE;
  assign o_done = state_q == DONE;
  assign o_rx_frame = rx_q;
  assign o_len_err = len_err_q;
  assign m_axis_tvalid = state_q == CONF || state_q == DATA;
  assign m_axis_tdata = state_q == CONF ? {2'b00, mode_q, rate_q, constr_q, poly_q} :
                        state_q == DATA ? tx_q[383:352] : 32'd0;
  assign m_axis_tlast = state_q == CONF || (state_q == DATA && cnt_q == (mode_q ? 4'd11 : 4'd3));
  assign s_axis_tready = state_q == RECV;
`ifdef ENDEC_HOST_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [WW-1:0] wd_q;
  logic timeout_q;
  assign expire = act && wd_q == WW'(TIMEOUT_CYCLES - 1);
  assign o_timeout = timeout_q;
  always_ff @(posedge sys_clk)
    if (!rst_n) begin
      wd_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_q <= (!act || state_d != state_q || m_hs || s_hs) ? '0 : wd_q + WW'(1);
      timeout_q <= (state_q == IDLE && i_start) ? 1'b0 : (expire ? 1'b1 : timeout_q);
    end
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
  assign expire = 1'b0;
  assign o_timeout = 1'b0;
`endif
  always_ff @(posedge sys_clk)
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      mode_q <= 1'b0;
      rate_q <= 1'b0;
      constr_q <= 1'b0;
      poly_q <= '0;
      tx_q <= '0;
      rx_q <= '0;
      len_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      mode_q <= mode_d;
      rate_q <= rate_d;
      constr_q <= constr_d;
      poly_q <= poly_d;
      tx_q <= tx_d;
      rx_q <= rx_d;
      len_err_q <= len_err_d;
    end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    mode_d = mode_q;
    rate_d = rate_q;
    constr_d = constr_q;
    poly_d = poly_q;
    tx_d = tx_q;
    rx_d = rx_q;
    len_err_d = len_err_q;
    case (state_q)
      IDLE: if (i_start) begin
        mode_d = i_mode;
        rate_d = i_code_rate;
        constr_d = i_constr_len;
        poly_d = i_gen_poly;
        // encode payload is pre-aligned to the top so both modes shift out of [383:352]
        tx_d = i_mode ? i_tx_frame : {i_tx_frame[127:0], 256'd0};
        rx_d = '0;
        len_err_d = 1'b0;
        state_d = CONF;
      end
      CONF: if (m_hs) state_d = DATA;
      DATA: if (m_hs) begin
        tx_d = {tx_q[351:0], 32'd0};
        cnt_d = cnt_q + 4'd1;
        if (m_axis_tlast) state_d = RECV;
      end
      RECV: if (s_hs) begin
        for (int w = 0; w < 12; w++) if (w == int'(widx)) rx_d[32*w +: 32] = s_axis_tdata;
        cnt_d = cnt_q + 4'd1;
        if (s_axis_tlast || s_end) begin
          len_err_d = s_axis_tlast != s_end;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (expire) state_d = DONE;
    if (state_d != state_q) cnt_d = '0;
  end
endmodule
